reg_bus_mstr: RTL and testbench
===============================

# reg_bus_mstr

Register-bus initiator that turns single host requests into reads and writes on the on-chip reg bus (reg_cs/reg_wr/reg_addr/reg_wdata/reg_be, answered by reg_rdata/reg_ack). It is the initiator counterpart of config/status responders such as the global config block. Host-side requests and responses use valid/ready handshakes. An optional timeout ends accesses that a responder never acknowledges.

## Interface
- ADDR_W, 8, reg bus address width
- DATA_W, 32, data width; byte enables are DATA_W/8
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort (≥2)
- mclk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  host request valid
- req_ready  output  1  request accepted when high with req_valid
- req_wr  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  byte address, passed through unchanged
- req_wdata  input  DATA_W  write data
- req_be  input  DATA_W/8  byte enables
- rsp_valid  output  1  response valid
- rsp_ready  input  1  host takes the response
- rsp_rdata  output  DATA_W  read data; write-ack data is 0
- rsp_err  output  1  access timed out
- reg_cs, reg_wr  output  1  bus select and direction
- reg_addr  output  ADDR_W, reg_wdata  output  DATA_W, reg_be  output  DATA_W/8  bus request fields
- reg_rdata  input  DATA_W, reg_ack  input  1  bus response
- tmo_cnt  output  8  count of timeouts, saturating

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch wr/addr/wdata/be into the bus output registers, set reg_cs=1 and go to ACCESS.
- ACCESS:
  - reg_cs=1 and all bus fields are held stable.
  - On a sampled reg_ack=1:
    - reg_cs<=0.
    - rsp_rdata<=reg_rdata for a read, 0 for a write.
    - rsp_err<=0, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_* are held stable until rsp_valid&rsp_ready, then rsp_valid<=0 and go to IDLE.
  - req_ready=0 throughout.
- reg_ack is ignored outside ACCESS; a late ack never creates a response.
- Timeout (macro enabled):
  - The counter clears on entry to ACCESS and increments every ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack:
    - reg_cs<=0, rsp_rdata<=all ones, rsp_err<=1, go to RESP.
    - tmo_cnt increments, saturating at 8'hFF.
  - An ack in the same cycle as the timeout wins; the access is a normal completion.
- Write data is only driven during a write; reg_wdata holds its last value otherwise.
- All outputs are registered.

## Timing
- Reset values:
  - reg_cs=0, reg_wr=0, reg_addr=0, reg_wdata=0, reg_be=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, tmo_cnt=0.
  - req_ready=1.
- Accept at edge E0 → reg_cs high from cycle 1.
- For a responder that acks one cycle after select:
  - ack is high in cycle 2.
  - reg_cs is low and rsp_valid high in cycle 3.
  - The response arrives 3 cycles after the accept cycle.
- With rsp_ready tied high the FSM is back in IDLE at cycle 4, giving one transaction per 4 cycles.
- reg_cs is low for at least 2 cycles between accesses (RESP and IDLE). This lets the responder's ack drop first.
- reg_cs is never high in the cycle after an ack is sampled, so a responder that acks on cs&!ack sees exactly one access.
- Reset asserted mid-ACCESS or mid-RESP:
  - All outputs return to reset values immediately (asynchronously).
  - The in-flight request is dropped with no response.

## Configuration
- REG_MSTR_TIMEOUT_EN defined: the timeout counter and tmo_cnt are present and operate as described.
- REG_MSTR_TIMEOUT_EN undefined:
  - ACCESS waits indefinitely for reg_ack.
  - rsp_err is tied to 0 and tmo_cnt is tied to 0.
  - TIMEOUT_CYCLES is unused.

## Structure
- Shared package reg_mstr_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the timeout read-data constant (all ones);
  - the tmo_cnt width constant (8).
- One sub-module, reg_mstr_tmo, holds the timeout counter and the saturating tmo_cnt.
  - Inputs: clear, run, ack. Outputs: expire, tmo_cnt.
  - It is instantiated only when REG_MSTR_TIMEOUT_EN is defined.

## Test plan
- Write 0x20 (reg 8), wdata 32'h1234_5678, be 4'hF, into the global config responder:
  - reg_cs is high for exactly 2 cycles.
  - rsp_valid comes 3 cycles after accept, with rsp_err=0 and rsp_rdata=0.
  - A following read of 0x20 returns 32'h1234_5678.
- Read 0x24 (reg 9) returns rsp_rdata=32'h4C66_8354, rsp_err=0. A read of 0x2C returns 32'h0001_6000.
- Responder never acks, TIMEOUT_CYCLES=16, macro enabled:
  - reg_cs drops after 16 cycles high.
  - rsp_err=1, rsp_rdata=32'hFFFF_FFFF, tmo_cnt=1.
  - A late ack 3 cycles afterwards produces no extra response.
- rsp_ready held low for 5 cycles after rsp_valid:
  - rsp_rdata and rsp_err stay stable.
  - req_ready=0 and reg_cs=0 throughout.
  - A new request is accepted only after the handshake.
- reset_n pulsed low in cycle 1 of ACCESS:
  - reg_cs=0 and rsp_valid=0 immediately.
  - req_ready=1 after release.
  - A new read completes normally.
- Ten back-to-back reads with rsp_ready=1 complete in 40 cycles, with ≥2 low cycles of reg_cs between accesses.

Source files
------------

// File: rtl/reg_mstr_pkg.sv
// Shared types and constants for the reg bus initiator.
// Used by reg_bus_mstr and reg_mstr_tmo.
package reg_mstr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam int TMO_CNT_W = 8;
  localparam int MAX_DATA_W = 1024;

  localparam logic [MAX_DATA_W-1:0] TMO_RDATA = '1;

endpackage

// File: rtl/reg_bus_mstr_if.sv
// Host request/response handshakes plus the reg bus.
// master: the initiator; slave: host and responder side.
interface reg_bus_mstr_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  localparam int BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              reg_cs;
  logic              reg_wr;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [BE_W-1:0]   reg_be;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_ack;

  modport master (
    input  req_valid, req_wr, req_addr,
    input  req_wdata, req_be,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output reg_cs, reg_wr, reg_addr,
    output reg_wdata, reg_be,
    input  reg_rdata, reg_ack
  );

  modport slave (
    output req_valid, req_wr, req_addr,
    output req_wdata, req_be,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  reg_cs, reg_wr, reg_addr,
    input  reg_wdata, reg_be,
    output reg_rdata, reg_ack
  );

endinterface

// File: rtl/reg_mstr_tmo.sv
// Access timeout counter and saturating count of timeouts.
// Instantiated only when REG_MSTR_TIMEOUT_EN is defined.
module reg_mstr_tmo
  import reg_mstr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 mclk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 run,
  input  logic                 ack,
  output logic                 expire,
  output logic [TMO_CNT_W-1:0] tmo_cnt
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // an ack in the expiring cycle wins
  assign expire = run && !ack && (cnt == LAST);

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      tmo_cnt <= '0;
    end else begin
      if (clear)
        cnt <= '0;
      else if (run && !ack)
        cnt <= cnt + 1'b1;
      if (expire && tmo_cnt != '1)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reg_bus_mstr.sv
// Reg bus initiator: one host request -> one reg bus access.
// REG_MSTR_TIMEOUT_EN adds the access timeout and tmo_cnt.
module reg_bus_mstr
  import reg_mstr_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 mclk,
  input  logic                 reset_n,
  reg_bus_mstr_if.master       bus,
  output logic [TMO_CNT_W-1:0] tmo_cnt
);

  localparam int BE_W = DATA_W / 8;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  state_e            state_q, state_d;
  logic              cs_q, cs_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rv_q, rv_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              rdy_q, rdy_d;
  logic              expire;

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rv_d    = rv_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = ACCESS;
          cs_d    = 1'b1;
          wr_d    = bus.req_wr;
          addr_d  = bus.req_addr;
          be_d    = bus.req_be;
          rdy_d   = 1'b0;
          if (bus.req_wr)
            wdata_d = bus.req_wdata;
        end
      end
      ACCESS: begin
        if (bus.reg_ack) begin
          state_d = RESP;
          cs_d    = 1'b0;
          rdata_d = wr_q ? '0 : bus.reg_rdata;
          err_d   = 1'b0;
          rv_d    = 1'b1;
        end else if (expire) begin
          state_d = RESP;
          cs_d    = 1'b0;
          rdata_d = TMO_RDATA[DATA_W-1:0];
          err_d   = 1'b1;
          rv_d    = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rv_d    = 1'b0;
          rdy_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.reg_cs    = cs_q;
  assign bus.reg_wr    = wr_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_be    = be_q;

`ifdef REG_MSTR_TIMEOUT_EN
  reg_mstr_tmo #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .mclk    (mclk),
    .reset_n (reset_n),
    .clear   (state_q == IDLE && bus.req_valid),
    .run     (state_q == ACCESS),
    .ack     (bus.reg_ack),
    .expire  (expire),
    .tmo_cnt (tmo_cnt)
  );
`else
  assign expire  = 1'b0;
  assign tmo_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_bus_mstr.sv
// Randomized bench for reg_bus_mstr against a transaction-level model.
// Timeout cases run only when REG_MSTR_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_reg_bus_mstr;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 16;
`ifdef REG_MSTR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       mclk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tmo_cnt;

  reg_bus_mstr_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  reg_bus_mstr #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .mclk    (mclk),
    .reset_n (reset_n),
    .bus     (bus.master),
    .tmo_cnt (tmo_cnt)
  );

  always #5 mclk = ~mclk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, got, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
    input logic [31:0] nw, input logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) merge[b*8 +: 8] = nw[b*8 +: 8];
  endfunction

  // power-on contents of the config responder
  function automatic logic [31:0] init_val(input int i);
    if (i == 9) return 32'h4C66_8354;
    if (i == 11) return 32'h0001_6000;
    return 32'h0;
  endfunction

  // ---------------- responder ----------------
  logic        resp_ack;
  logic        force_ack = 1'b0;
  bit          resp_en = 1'b1;
  int          lat = 0;
  int          wcnt;
  logic [31:0] resp_rdata;
  logic [31:0] rmem [64];

  assign bus.reg_ack   = resp_ack | force_ack;
  assign bus.reg_rdata = resp_rdata;

  always @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      resp_ack   <= 1'b0;
      resp_rdata <= '0;
      wcnt       <= 0;
      for (int i = 0; i < 64; i++) rmem[i] <= init_val(i);
    end else if (resp_ack) begin
      resp_ack <= 1'b0;
    end else if (!bus.reg_cs) begin
      wcnt <= 0;
    end else if (resp_en) begin
      if (wcnt >= lat) begin
        resp_ack <= 1'b1;
        wcnt     <= 0;
        if (bus.reg_wr)
          rmem[bus.reg_addr[7:2]] <= merge(rmem[bus.reg_addr[7:2]],
                                           bus.reg_wdata, bus.reg_be);
        else
          resp_rdata <= rmem[bus.reg_addr[7:2]];
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // ---------------- model ----------------
  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } txn_t;

  txn_t        q[$];
  logic [31:0] ref_mem [64];
  logic [31:0] last_wdata = '0;
  int          tmo_exp = 0;
  int          cyc = 0;
  int          last_acc = 0;

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic ref_init();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    last_wdata = '0;
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    txn_t t;
    int   n = 0;
    int   acc;
    bit   tmo;
    @(negedge mclk);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    while (bus.req_ready !== 1'b1) begin
      n++;
      if (n > 300) begin
        chk("accept_bound", 0, 1);
        bus.req_valid = 1'b0;
        return;
      end
      @(negedge mclk);
    end
    acc = cyc;
    @(posedge mclk);
    #1;
    bus.req_valid = 1'b0;
    tmo = TMO_EN && (!resp_en || lat + 2 > TMO);
    t.wr = wr; t.addr = addr; t.be = be; t.acc = acc;
    if (wr) last_wdata = wd;
    if (tmo) begin
      t.rdata = '1; t.err = 1'b1; t.lat = TMO + 1;
      tmo_exp++;
    end else begin
      t.err = 1'b0; t.lat = lat + 3;
      if (wr) begin
        t.rdata = '0;
        ref_mem[addr[7:2]] = merge(ref_mem[addr[7:2]], wd, be);
      end else begin
        t.rdata = ref_mem[addr[7:2]];
      end
    end
    last_acc = acc;
    q.push_back(t);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (q.size() != 0) begin
      n++;
      if (n > bound) begin
        chk("idle_bound", q.size(), 0);
        return;
      end
      @(negedge mclk);
    end
  endtask

  // ---------------- compare process ----------------
  bit          mon_en = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          rsp_seen = 1'b0;
  bit          prev_ack_cs = 1'b0;
  int          hold = 0;
  int          hold_next = 0;
  int          cs_run = 0;
  int          cs_gap = 2;
  int          last_cs_len = 0;
  int          last_hs = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  always @(negedge mclk) begin
    if (mon_en) begin
      chk("req_ready", bus.req_ready, 64'(q.size() == 0));
      if (bus.reg_cs) begin
        if (q.size() == 0) begin
          chk("cs_idle", 1, 0);
        end else begin
          chk("reg_wr", bus.reg_wr, q[0].wr);
          chk("reg_addr", bus.reg_addr, q[0].addr);
          chk("reg_be", bus.reg_be, q[0].be);
        end
        chk("reg_wdata", bus.reg_wdata, last_wdata);
        if (cs_run == 0) chk("cs_gap", 64'(cs_gap >= 2), 1);
        chk("cs_after_ack", prev_ack_cs, 0);
        cs_run++;
        cs_gap = 0;
      end else begin
        if (cs_run != 0) last_cs_len = cs_run;
        cs_run = 0;
        cs_gap++;
      end
      prev_ack_cs = bus.reg_cs && bus.reg_ack;
      bus.rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.rsp_valid) begin
        chk("rsp_cs_low", bus.reg_cs, 0);
        if (q.size() == 0) begin
          chk("spurious_rsp", 1, 0);
        end else begin
          if (!rsp_seen) begin
            chk("rsp_latency", cyc - q[0].acc, q[0].lat);
            rsp_seen  = 1'b1;
            hold      = hold_next;
            hold_next = 0;
          end
          chk("rsp_rdata", bus.rsp_rdata, q[0].rdata);
          chk("rsp_err", bus.rsp_err, q[0].err);
          chk("tmo_cnt", tmo_cnt, tmo_exp);
          if (hold > 0) begin
            hold--;
            bus.rsp_ready = 1'b0;
          end
          if (bus.rsp_ready) begin
            last_rdata = bus.rsp_rdata;
            last_err   = bus.rsp_err;
            last_hs    = cyc;
            rsp_seen   = 1'b0;
            void'(q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int a0;
    int h0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b1;
    ref_init();
    repeat (3) @(negedge mclk);
    chk("rst_cs", bus.reg_cs, 0);
    chk("rst_wr", bus.reg_wr, 0);
    chk("rst_addr", bus.reg_addr, 0);
    chk("rst_wdata", bus.reg_wdata, 0);
    chk("rst_be", bus.reg_be, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_tmo_cnt", tmo_cnt, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    reset_n = 1'b1;
    @(negedge mclk);
    mon_en = 1'b1;

    issue(1'b1, 8'h20, 32'h1234_5678, 4'hF);
    wait_idle(50);
    chk("wr_cs_len", last_cs_len, 2);
    chk("wr_rdata", last_rdata, 0);
    chk("wr_err", last_err, 0);
    issue(1'b0, 8'h20, 32'h0, 4'hF);
    wait_idle(50);
    chk("rd_0x20", last_rdata, 32'h1234_5678);
    issue(1'b0, 8'h24, 32'h0, 4'hF);
    wait_idle(50);
    chk("rd_0x24", last_rdata, 32'h4C66_8354);
    issue(1'b0, 8'h2C, 32'h0, 4'hF);
    wait_idle(50);
    chk("rd_0x2c", last_rdata, 32'h0001_6000);

    hold_next = 5;
    issue(1'b0, 8'h2C, 32'h0, 4'hF);
    h0 = last_acc;
    issue(1'b0, 8'h24, 32'h0, 4'hF);
    chk("hold_hs_cycle", last_hs - h0, 8);
    chk("accept_after_hs", last_acc - last_hs, 1);
    wait_idle(50);

`ifdef REG_MSTR_TIMEOUT_EN
    resp_en = 1'b0;
    issue(1'b0, 8'h30, 32'h0, 4'hF);
    wait_idle(100);
    chk("tmo_cs_len", last_cs_len, 16);
    chk("tmo_err", last_err, 1);
    chk("tmo_rdata", last_rdata, 32'hFFFF_FFFF);
    chk("tmo_cnt_1", tmo_cnt, 1);
    resp_en = 1'b1;
    repeat (2) @(negedge mclk);
    force_ack = 1'b1;
    @(negedge mclk);
    force_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge mclk);
      chk("late_ack_rsp", bus.rsp_valid, 0);
    end
`endif

    lat = 14;
    issue(1'b0, 8'h24, 32'h0, 4'hF);
    wait_idle(100);
    chk("lat14_err", last_err, 0);
    chk("lat14_rdata", last_rdata, 32'h4C66_8354);
    lat = 15;
    issue(1'b0, 8'h24, 32'h0, 4'hF);
    wait_idle(100);
    chk("lat15_err", last_err, TMO_EN);
    lat = 0;

    issue(1'b0, 8'h24, 32'h0, 4'hF);
    chk("acc_cs", bus.reg_cs, 1);
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_cs", bus.reg_cs, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    q.delete();
    ref_init();
    tmo_exp     = 0;
    rsp_seen    = 1'b0;
    prev_ack_cs = 1'b0;
    cs_run      = 0;
    cs_gap      = 2;
    repeat (2) @(negedge mclk);
    reset_n = 1'b1;
    @(negedge mclk);
    chk("arst_req_ready", bus.req_ready, 1);
    mon_en = 1'b1;
    issue(1'b0, 8'h2C, 32'h0, 4'hF);
    wait_idle(50);
    chk("post_rst_rd", last_rdata, 32'h0001_6000);

    issue(1'b0, 8'h24, 32'h0, 4'hF);
    a0 = last_acc;
    for (int i = 1; i < 10; i++)
      issue(1'b0, 8'(i * 4), 32'h0, 4'hF);
    wait_idle(50);
    chk("b2b_cycles", last_hs - a0 + 1, 40);

    rdy_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      lat = $urandom_range(0, 3);
      issue(1'($urandom_range(0, 1)), {6'($urandom), 2'b00},
            $urandom, 4'($urandom));
      wait_idle(80);
    end
    rdy_rand = 1'b0;
    for (int i = 0; i < 64; i++) begin
      lat = 0;
      issue(1'b0, 8'(i * 4), 32'h0, 4'hF);
      wait_idle(50);
      chk("final_mem", last_rdata, ref_mem[i]);
    end

    repeat (3) @(negedge mclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
